// File: rtl/txn_credit_tracker_pkg.sv
// txn_credit_tracker_pkg: shared types and channel indices for the TXN credit tracker.
// Revision 1.0
`default_nettype none

package txn_credit_tracker_pkg;

    typedef enum logic {OPEN = 1'b0, STOPPED = 1'b1} stop_state_t;

    localparam int TXN_CH_READ  = 0;
    localparam int TXN_CH_WRITE = 1;

endpackage

`default_nettype wire

// File: rtl/txn_credit_cnt.sv
// txn_credit_cnt: one channel of the tracker (saturating counter, hysteretic stop FSM,
// optional peak register under TXN_CREDIT_TRACKER_STATS_EN).  Revision 1.0
`default_nettype none

module txn_credit_cnt #(
    parameter int DEPTH   = 16,
    parameter int HI_MARK = 16,
    parameter int LO_MARK = 15,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
`ifdef TXN_CREDIT_TRACKER_STATS_EN
    input  logic             peak_clr,
    output logic [CNT_W-1:0] peak_occ,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             stop,
    output logic             err_ovf,
    output logic             err_unf
);
    import txn_credit_tracker_pkg::*;

    localparam logic [0:0]       ST_OPEN    = 1'(OPEN);
    localparam logic [0:0]       ST_STOPPED = 1'(STOPPED);
    localparam logic [CNT_W-1:0] c_full     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_hi       = CNT_W'(HI_MARK);
    localparam logic [CNT_W-1:0] c_lo       = CNT_W'(LO_MARK);

    logic [CNT_W-1:0] r_cnt;
    logic [0:0]       r_state;
    logic             r_err_ovf;
    logic             r_err_unf;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [0:0]       w_state_nxt;
    logic             w_ovf;
    logic             w_unf;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        if (inc && !dec) begin
            if (r_cnt == c_full) w_ovf = 1'b1;
            else                 w_cnt_nxt = r_cnt + 1'b1;
        end else if (dec && !inc) begin
            if (r_cnt == '0) w_unf = 1'b1;
            else             w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // Stop follows the next count so it moves on the same edge as the counter.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OPEN:    if (w_cnt_nxt >= c_hi) w_state_nxt = ST_STOPPED;
            ST_STOPPED: if (w_cnt_nxt <= c_lo) w_state_nxt = ST_OPEN;
            default:    w_state_nxt = ST_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_state   <= ST_OPEN;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            if (w_ovf) r_err_ovf <= 1'b1;
            if (w_unf) r_err_unf <= 1'b1;
        end
    end

`ifdef TXN_CREDIT_TRACKER_STATS_EN
    logic [CNT_W-1:0] r_peak;

    always_ff @(posedge clk) begin
        if (!rst_n)                  r_peak <= '0;
        else if (peak_clr)           r_peak <= w_cnt_nxt;
        else if (w_cnt_nxt > r_peak) r_peak <= w_cnt_nxt;
    end

    assign peak_occ = r_peak;
`endif

    assign cnt     = r_cnt;
    assign stop    = (r_state == ST_STOPPED);
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;

endmodule

`default_nettype wire

// File: rtl/txn_credit_tracker.sv
// txn_credit_tracker: N-channel outstanding-transaction tracker with hysteretic stop.
// Optional peak statistics: TXN_CREDIT_TRACKER_STATS_EN.  Revision 1.0
`default_nettype none

module txn_credit_tracker #(
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 16,
    parameter int HI_MARK = DEPTH,
    parameter int LO_MARK = DEPTH - 1,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic [CH_W-1:0]         req_ch,
    input  logic [NUM_CH-1:0]       done,
`ifdef TXN_CREDIT_TRACKER_STATS_EN
    input  logic                    peak_clr,
    output logic [NUM_CH*CNT_W-1:0] peak_occ,
`endif
    output logic [NUM_CH-1:0]       stop,
    output logic [NUM_CH*CNT_W-1:0] occ,
    output logic                    err_overflow,
    output logic                    err_underflow,
    output logic                    err_bad_ch
);
    import txn_credit_tracker_pkg::*;

    if (!(LO_MARK >= 0 && LO_MARK < HI_MARK && HI_MARK <= DEPTH && NUM_CH >= 1))
    begin : g_param_check
        $error("txn_credit_tracker: need 0 <= LO_MARK < HI_MARK <= DEPTH and NUM_CH >= 1");
    end

    logic [NUM_CH-1:0] w_inc;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_unf;
    logic              w_bad_ch;
    logic              r_err_bad_ch;

    // Widened compare so a power-of-two NUM_CH never truncates the bound.
    assign w_bad_ch = req_valid && ({1'b0, req_ch} >= (CH_W + 1)'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_inc[i] = req_valid && (req_ch == CH_W'(i));

        txn_credit_cnt #(
            .DEPTH   (DEPTH),
            .HI_MARK (HI_MARK),
            .LO_MARK (LO_MARK),
            .CNT_W   (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (w_inc[i]),
            .dec      (done[i]),
`ifdef TXN_CREDIT_TRACKER_STATS_EN
            .peak_clr (peak_clr),
            .peak_occ (peak_occ[i*CNT_W +: CNT_W]),
`endif
            .cnt      (occ[i*CNT_W +: CNT_W]),
            .stop     (stop[i]),
            .err_ovf  (w_ovf[i]),
            .err_unf  (w_unf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        r_err_bad_ch <= 1'b0;
        else if (w_bad_ch) r_err_bad_ch <= 1'b1;
    end

    assign err_overflow  = |w_ovf;
    assign err_underflow = |w_unf;
    assign err_bad_ch    = r_err_bad_ch;

endmodule

`default_nettype wire
